// File: rtl/alt_sfl_arb_pkg.sv
// Shared types and constants for the ASMI flash-port arbiter.
package alt_sfl_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2,
        StGap  = 2'd3
    } arb_state_e;

    localparam int unsigned PRIO_RR     = 0;
    localparam int unsigned PRIO_FIXED0 = 1;

    // Values driven onto the ASMI port while nobody owns it.
    localparam logic       PARK_DCLK  = 1'b0;
    localparam logic       PARK_SCE   = 1'b1;
    localparam logic       PARK_SDO   = 1'b0;
    localparam logic [1:0] PARK_DATA0 = 2'b00;

    function automatic logic [1:0] grant_of(input arb_state_e st);
        case (st)
            StOwn0:  return 2'b01;
            StOwn1:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/alt_sfl_asmi_mux.sv
// Combinational owner mux for the ASMI port; parks the port when no owner is valid.
module alt_sfl_asmi_mux
    import alt_sfl_arb_pkg::*;
(
    input  logic       owner,
    input  logic       owner_valid,
    input  logic [1:0] dclk,
    input  logic [1:0] sce,
    input  logic [1:0] sdo,
    input  logic       asmi_data0,
    output logic       asmi_dclk,
    output logic       asmi_sce,
    output logic       asmi_sdo,
    output logic [1:0] data0
);

    always_comb begin
        asmi_dclk = PARK_DCLK;
        asmi_sce  = PARK_SCE;
        asmi_sdo  = PARK_SDO;
        data0     = PARK_DATA0;
        if (owner_valid) begin
            asmi_dclk    = dclk[owner];
            asmi_sce     = sce[owner];
            asmi_sdo     = sdo[owner];
            data0[owner] = asmi_data0;
        end
    end

endmodule

// File: rtl/alt_sfl_asmi_arbiter.sv
// Two-requester ASMI serial-flash port arbiter with guard gap between owners.
// Optional idle-owner revocation is enabled by defining ALT_SFL_ARB_TIMEOUT_EN.
module alt_sfl_asmi_arbiter
    import alt_sfl_arb_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 11
) (
    input  logic       clock,
    input  logic       aclr,
    input  logic [1:0] req,
    input  logic [1:0] dclk,
    input  logic [1:0] sce,
    input  logic [1:0] sdo,
    output logic [1:0] grant,
    output logic [1:0] data0,
    output logic       asmi_dclk,
    output logic       asmi_sce,
    output logic       asmi_sdo,
    input  logic       asmi_data0,
    output logic       busy,
    output logic       timeout_pulse
);

    localparam arb_state_e EXIT_STATE = (GAP_CYCLES > 0) ? StGap : StIdle;
    localparam logic [CNT_WIDTH-1:0] GAP_LAST = CNT_WIDTH'(GAP_CYCLES - 1);

    arb_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 last_owner_q, last_owner_d;
    logic [1:0]           sce_q;
    logic [1:0]           grant_q;
    logic                 busy_q;
    logic                 timeout_q, timeout_d;
    logic                 own_idx;
    logic                 pick;
    logic                 release_ok;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

`ifdef ALT_SFL_ARB_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        timeout_d    = 1'b0;
        own_idx      = (state_q == StOwn1);
        // nCS must be seen high on this and the previous sample before hand-back.
        release_ok   = !req[own_idx] && sce[own_idx] && sce_q[own_idx];
        pick         = req[1];
        if (req[0] && req[1]) begin
            pick = (PRIORITY_MODE == PRIO_FIXED0) ? 1'b0 : !last_owner_q;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (|req) begin
                    state_d      = pick ? StOwn1 : StOwn0;
                    last_owner_d = pick;
                end
            end
            StOwn0, StOwn1: begin
                if (release_ok) begin
                    state_d = EXIT_STATE;
                    cnt_d   = '0;
                end
`ifdef ALT_SFL_ARB_TIMEOUT_EN
                else if (sce[own_idx] && req[!own_idx]) begin
                    if (cnt_q == TO_LAST) begin
                        state_d   = EXIT_STATE;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end else begin
                    cnt_d = '0;
                end
`endif
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_owner_q <= 1'b1;
            sce_q        <= 2'b11;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            sce_q        <= sce;
            grant_q      <= grant_of(state_d);
            busy_q       <= (state_d != StIdle);
            timeout_q    <= timeout_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = busy_q;
    assign timeout_pulse = timeout_q;

    alt_sfl_asmi_mux u_mux (
        .owner       (state_q == StOwn1),
        .owner_valid ((state_q == StOwn0) || (state_q == StOwn1)),
        .dclk        (dclk),
        .sce         (sce),
        .sdo         (sdo),
        .asmi_data0  (asmi_data0),
        .asmi_dclk   (asmi_dclk),
        .asmi_sce    (asmi_sce),
        .asmi_sdo    (asmi_sdo),
        .data0       (data0)
    );

endmodule

// File: tb/tb_alt_sfl_asmi_arbiter.sv
// Directed self-checking bench for alt_sfl_asmi_arbiter (round-robin and fixed-priority instances).
module tb_alt_sfl_asmi_arbiter;

    logic       clock = 1'b0;
    logic       aclr;
    logic [1:0] req, dclk, sce, sdo;
    logic       asmi_data0;

    logic [1:0] grant, data0, grant_p, data0_p;
    logic       asmi_dclk, asmi_sce, asmi_sdo, busy, timeout_pulse;
    logic       asmi_dclk_p, asmi_sce_p, asmi_sdo_p, busy_p, timeout_pulse_p;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    alt_sfl_asmi_arbiter #(
        .PRIORITY_MODE(0), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16), .CNT_WIDTH(11)
    ) dut (
        .clock(clock), .aclr(aclr), .req(req), .dclk(dclk), .sce(sce), .sdo(sdo),
        .grant(grant), .data0(data0), .asmi_dclk(asmi_dclk), .asmi_sce(asmi_sce),
        .asmi_sdo(asmi_sdo), .asmi_data0(asmi_data0), .busy(busy),
        .timeout_pulse(timeout_pulse)
    );

    alt_sfl_asmi_arbiter #(
        .PRIORITY_MODE(1), .GAP_CYCLES(4), .TIMEOUT_CYCLES(16), .CNT_WIDTH(11)
    ) dut_p (
        .clock(clock), .aclr(aclr), .req(req), .dclk(dclk), .sce(sce), .sdo(sdo),
        .grant(grant_p), .data0(data0_p), .asmi_dclk(asmi_dclk_p), .asmi_sce(asmi_sce_p),
        .asmi_sdo(asmi_sdo_p), .asmi_data0(asmi_data0), .busy(busy_p),
        .timeout_pulse(timeout_pulse_p)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        aclr = 1'b1; req = 2'b00; sce = 2'b11; dclk = 2'b00; sdo = 2'b00; asmi_data0 = 1'b0;
        #2;
        aclr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        aclr = 1'b1; req = 2'b11; sce = 2'b00; dclk = 2'b11; sdo = 2'b11; asmi_data0 = 1'b1;
        #2;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b want 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_pulse); end
        checks++; if ({asmi_sce, asmi_dclk, asmi_sdo} !== 3'b100) begin errors++; $display("FAIL reset_park: sce/dclk/sdo got %b want 100", {asmi_sce, asmi_dclk, asmi_sdo}); end
        checks++; if (data0 !== 2'b00) begin errors++; $display("FAIL reset_data0: got %b want 00", data0); end
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_hold_grant: got %b want 00", grant); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 2'b01;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b want 01", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        dclk = 2'b01; sce = 2'b10; sdo = 2'b01; asmi_data0 = 1'b1;
        #1;
        checks++; if ({asmi_sce, asmi_dclk, asmi_sdo} !== 3'b011) begin errors++; $display("FAIL single_mux: sce/dclk/sdo got %b want 011", {asmi_sce, asmi_dclk, asmi_sdo}); end
        checks++; if (data0 !== 2'b01) begin errors++; $display("FAIL single_data0: got %b want 01", data0); end
        dclk = 2'b10; sdo = 2'b10; asmi_data0 = 1'b0;
        #1;
        checks++; if ({asmi_dclk, asmi_sdo, data0} !== 4'b0000) begin errors++; $display("FAIL single_mux_low: dclk/sdo/data0 got %b want 0000", {asmi_dclk, asmi_sdo, data0}); end
        sce = 2'b11;
        tick();
        req = 2'b00;
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b want 00", grant); end
        checks++; if (asmi_sce !== 1'b1) begin errors++; $display("FAIL single_park_sce: got %b want 1", asmi_sce); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy: got %b want 1", busy); end
        repeat (3) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_gap_end_busy: got %b want 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_handoff();
        do_reset();
        req = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL handoff_first: got %b want 01", grant); end
        tick();
        req = 2'b10;
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL handoff_release: got %b want 00", grant); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (grant !== 2'b00) begin errors++; $display("FAIL handoff_gap%0d: got %b want 00", i, grant); end
        end
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL handoff_second: got %b want 10", grant); end
        dclk = 2'b10; sce = 2'b01; sdo = 2'b10; asmi_data0 = 1'b1;
        #1;
        checks++; if ({asmi_sce, asmi_dclk, asmi_sdo, data0} !== 5'b01110) begin errors++; $display("FAIL handoff_mux1: got %b want 01110", {asmi_sce, asmi_dclk, asmi_sdo, data0}); end
        do_reset();
    endtask

    task automatic test_release_during_cmd();
        int bad;
        do_reset();
        req = 2'b01;
        tick();
        sce = 2'b10;
        tick();
        req = 2'b00;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (grant !== 2'b01) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL cmd_hold: %0d cycles lost grant, want 0", bad); end
        sce = 2'b11;
        tick();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cmd_one_high: got %b want 01", grant); end
        tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cmd_two_high: got %b want 00", grant); end
    endtask

    task automatic test_priority();
        logic [1:0] rr_exp;
        do_reset();
        req = 2'b11;
        tick();
        checks++; if (grant_p !== 2'b01) begin errors++; $display("FAIL prio_first: got %b want 01", grant_p); end
        rr_exp = 2'b10;
        for (int r = 0; r < 3; r++) begin
            req = 2'b00;
            tick();
            req = 2'b11;
            repeat (5) tick();
            checks++; if (grant_p !== 2'b01) begin errors++; $display("FAIL prio_round%0d: got %b want 01", r, grant_p); end
            checks++; if (grant !== rr_exp) begin errors++; $display("FAIL rr_round%0d: got %b want %b", r, grant, rr_exp); end
            rr_exp = ~rr_exp;
        end
    endtask

    task automatic test_aclr_mid_cmd();
        do_reset();
        req = 2'b01;
        tick();
        sce = 2'b10;
        #1;
        checks++; if (asmi_sce !== 1'b0) begin errors++; $display("FAIL aclr_pre_sce: got %b want 0", asmi_sce); end
        aclr = 1'b1;
        #1;
        checks++; if (asmi_sce !== 1'b1) begin errors++; $display("FAIL aclr_async_sce: got %b want 1", asmi_sce); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL aclr_async_grant: got %b want 00", grant); end
        aclr = 1'b0; req = 2'b00; sce = 2'b11;
        tick();
        checks++; if ({busy, grant} !== 3'b000) begin errors++; $display("FAIL aclr_idle: busy/grant got %b want 000", {busy, grant}); end
    endtask

    task automatic test_timeout();
        int bad;
        do_reset();
        req = 2'b01;
        tick();
        req = 2'b11;
        bad = 0;
`ifdef ALT_SFL_ARB_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (timeout_pulse !== 1'b0 || grant !== 2'b01) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL to_early: %0d bad cycles, want 0", bad); end
        tick();
        checks++; if (timeout_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b want 1", timeout_pulse); end
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_revoke: got %b want 00", grant); end
        tick();
        checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b want 0", timeout_pulse); end
        repeat (3) tick();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_gap: got %b want 00", grant); end
        tick();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL to_regrant: got %b want 10", grant); end
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            if (timeout_pulse !== 1'b0 || grant !== 2'b01) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL no_timeout_hold: %0d bad cycles, want 0", bad); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_handoff();
        test_release_during_cmd();
        test_priority();
        test_aclr_mid_cmd();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
